// File: rtl/sme_pkg.sv
// Shared types and constants for the string-matching engine (SME) job scheduler.
package sme_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND_STR,
    S_SEND_PAT,
    S_WAIT,
    S_RESP
  } sme_state_e;

  localparam int unsigned SME_STR_MAX  = 32;
  localparam int unsigned SME_PAT_MAX  = 8;
  localparam logic [4:0]  SME_IDX_NONE = 5'd31;

  // Characters the engine treats specially inside a pattern
  localparam logic [7:0] SME_CHR_BOL   = 8'h5E;  // '^'
  localparam logic [7:0] SME_CHR_EOL   = 8'h24;  // '$'
  localparam logic [7:0] SME_CHR_ANY   = 8'h2E;  // '.'
  localparam logic [7:0] SME_CHR_STAR  = 8'h2A;  // '*'
  localparam logic [7:0] SME_CHR_SPACE = 8'h20;  // ' '

endpackage

// File: rtl/sme_rr_arb.sv
// Round-robin arbiter: searches upward from last_gnt+1 and reports a one-hot grant;
// the pointer moves to adv_idx when adv is pulsed.
module sme_rr_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned GW   = (NREQ > 2) ? 2 : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  input  logic [GW-1:0]   adv_idx,
  output logic            gnt_any,
  output logic [GW-1:0]   gnt_idx,
  output logic [NREQ-1:0] gnt_oh
);

  logic [GW-1:0] last_gnt;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!gnt_any && req[(32'(last_gnt) + i) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_idx = GW'((32'(last_gnt) + i) % NREQ);
        gnt_oh[(32'(last_gnt) + i) % NREQ] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= GW'(NREQ - 1);
    end else if (adv) begin
      last_gnt <= adv_idx;
    end
  end

endmodule

// File: rtl/sme_job_sched.sv
// Shares one SME among NREQ requesters: buffer a job, replay it as gap-free bursts,
// return the engine result. Optional WAIT timeout: define SME_JOB_TIMEOUT_EN.
module sme_job_sched
  import sme_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TMO_CYC = 48
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_kind,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              rsp_match,
  output logic [4:0]        rsp_index,
  output logic              rsp_err,
  output logic [7:0]        sme_chardata,
  output logic              sme_isstring,
  output logic              sme_ispattern,
  input  logic              sme_valid,
  input  logic              sme_match,
  input  logic [4:0]        sme_match_index
);

  localparam int unsigned GW = (NREQ > 2) ? 2 : 1;
`ifdef SME_JOB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [5:0] TMO_LAST = 6'(TMO_CYC - 1);

  sme_state_e      state, state_d;
  logic [GW-1:0]   g, g_d;
  logic [NREQ-1:0] g_oh, g_oh_d;
  logic [5:0]      slen, slen_d;
  logic [3:0]      plen, plen_d;
  logic [5:0]      k, k_d;
  logic            err, err_d;
  logic [5:0]      wcnt, wcnt_d;

  logic [NREQ-1:0] req_ready_d, rsp_valid_d;
  logic            rsp_match_d, rsp_err_d;
  logic [4:0]      rsp_index_d;
  logic [7:0]      chardata_d;
  logic            isstring_d, ispattern_d;

  logic [7:0] sbuf [SME_STR_MAX];
  logic [7:0] pbuf [SME_PAT_MAX];

  logic            arb_adv, arb_any;
  logic [GW-1:0]   arb_idx;
  logic [NREQ-1:0] arb_oh;

  logic       xfer, cur_kind, cur_last;
  logic [7:0] cur_data, sbuf0, pbuf0;
  logic       s_bad, p_bad, s_wr, p_wr;

  sme_rr_arb #(.NREQ(NREQ), .GW(GW)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .adv     (arb_adv),
    .adv_idx (g),
    .gnt_any (arb_any),
    .gnt_idx (arb_idx),
    .gnt_oh  (arb_oh)
  );

  assign cur_data = req_data[{g, 3'b000} +: 8];
  assign cur_kind = req_kind[g];
  assign cur_last = req_last[g];
  assign xfer     = req_ready[g] & req_valid[g];
  assign s_bad    = ~cur_kind & ((slen == 6'(SME_STR_MAX)) | (plen != '0));
  assign p_bad    = cur_kind & (plen == 4'(SME_PAT_MAX));
  assign s_wr     = xfer & ~cur_kind & ~s_bad;
  assign p_wr     = xfer & cur_kind & ~p_bad;
  // Entry 0 may be written on the very edge that launches the burst
  assign sbuf0    = (s_wr && slen == '0) ? cur_data : sbuf[0];
  assign pbuf0    = (p_wr && plen == '0) ? cur_data : pbuf[0];

  always_comb begin
    state_d     = state;
    g_d         = g;
    g_oh_d      = g_oh;
    slen_d      = slen;
    plen_d      = plen;
    k_d         = k;
    err_d       = err;
    wcnt_d      = wcnt;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_match_d = rsp_match;
    rsp_index_d = rsp_index;
    rsp_err_d   = rsp_err;
    chardata_d  = '0;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    arb_adv     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (arb_any) begin
          g_d         = arb_idx;
          g_oh_d      = arb_oh;
          slen_d      = '0;
          plen_d      = '0;
          err_d       = 1'b0;
          req_ready_d = arb_oh;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        req_ready_d = g_oh;
        if (s_wr) slen_d = slen + 6'd1;
        if (p_wr) plen_d = plen + 4'd1;
        if (xfer && (s_bad || p_bad)) err_d = 1'b1;
        if (xfer && cur_last) begin
          req_ready_d = '0;
          k_d         = 6'd1;
          if (slen_d != '0) begin
            chardata_d = sbuf0;
            isstring_d = 1'b1;
            state_d    = S_SEND_STR;
          end else if (plen_d != '0) begin
            chardata_d  = pbuf0;
            ispattern_d = 1'b1;
            state_d     = S_SEND_PAT;
          end else begin
            err_d       = 1'b1;
            rsp_valid_d = g_oh;
            rsp_match_d = 1'b0;
            rsp_index_d = SME_IDX_NONE;
            rsp_err_d   = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      // k counts characters already on the output, so the last one is showing when k == len
      S_SEND_STR: begin
        if (k != slen) begin
          chardata_d = sbuf[k[4:0]];
          isstring_d = 1'b1;
          k_d        = k + 6'd1;
        end else if (plen != '0) begin
          chardata_d  = pbuf[0];
          ispattern_d = 1'b1;
          k_d         = 6'd1;
          state_d     = S_SEND_PAT;
        end else begin
          err_d       = 1'b1;
          rsp_valid_d = g_oh;
          rsp_match_d = 1'b0;
          rsp_index_d = SME_IDX_NONE;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_SEND_PAT: begin
        if (k != {2'b00, plen}) begin
          chardata_d  = pbuf[k[2:0]];
          ispattern_d = 1'b1;
          k_d         = k + 6'd1;
        end else begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sme_valid) begin
          rsp_valid_d = g_oh;
          rsp_match_d = sme_match;
          rsp_index_d = sme_match_index;
          rsp_err_d   = err;
          state_d     = S_RESP;
        end else if (TMO_EN && wcnt == TMO_LAST) begin
          rsp_valid_d = g_oh;
          rsp_match_d = 1'b0;
          rsp_index_d = SME_IDX_NONE;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          wcnt_d = wcnt + 6'd1;
        end
      end
      S_RESP: begin
        rsp_valid_d = g_oh;
        if (rsp_ready[g]) begin
          rsp_valid_d = '0;
          arb_adv     = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      g             <= '0;
      g_oh          <= '0;
      slen          <= '0;
      plen          <= '0;
      k             <= '0;
      err           <= 1'b0;
      wcnt          <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_match     <= 1'b0;
      rsp_index     <= SME_IDX_NONE;
      rsp_err       <= 1'b0;
      sme_chardata  <= '0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
    end else begin
      state         <= state_d;
      g             <= g_d;
      g_oh          <= g_oh_d;
      slen          <= slen_d;
      plen          <= plen_d;
      k             <= k_d;
      err           <= err_d;
      wcnt          <= wcnt_d;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_match     <= rsp_match_d;
      rsp_index     <= rsp_index_d;
      rsp_err       <= rsp_err_d;
      sme_chardata  <= chardata_d;
      sme_isstring  <= isstring_d;
      sme_ispattern <= ispattern_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s_wr) sbuf[slen[4:0]] <= cur_data;
    if (p_wr) pbuf[plen[2:0]] <= cur_data;
  end

endmodule
